// File: rtl/router_port_arbiter.sv
// Round-robin arbiter feeding a single registered output slot (EMPTY/FULL FSM).
// Optional per-requester grant counters are enabled with the ARB_STATS_EN macro.
module router_port_arbiter #(
   parameter int WIDTH_packet = 14,
   parameter int NUM_REQ      = 3,
   parameter int WIDTH_cnt    = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              in_valid,
   input  logic [NUM_REQ*WIDTH_packet-1:0] in_data,
   output logic [NUM_REQ-1:0]              in_ready,
   output logic                            out_valid,
   output logic [WIDTH_packet-1:0]         out_data,
   input  logic                            out_ready,
   output logic [1:0]                      grant_id,
   output logic                            busy
`ifdef ARB_STATS_EN
   ,
   output logic [NUM_REQ*WIDTH_cnt-1:0]    grant_cnt
`endif
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t                    state_r;
   state_t                    state_next_s;
   logic [1:0]                last_grant_r;
   logic [WIDTH_packet-1:0]   out_data_r;
   logic [1:0]                grant_id_r;

   logic [3:0]                in_valid_ext_s;
   logic                      win_found_s;
   logic [1:0]                win_idx_s;
   logic [2:0]                idx_v;
   logic                      slot_avail_s;
   logic                      accept_s;
   logic                      out_fire_s;
   logic [WIDTH_packet-1:0]   sel_data_s;

   // Parameter sanity checks at elaboration
   if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
      $error("router_port_arbiter: NUM_REQ must be 2..4");
   end
   if (WIDTH_cnt < 1 || WIDTH_packet < 1) begin : g_bad_width
      $error("router_port_arbiter: widths must be positive");
   end

   // Round-robin search starting one past the last accepted requester
   always_comb begin
      in_valid_ext_s = 4'(in_valid);
      win_found_s    = 1'b0;
      win_idx_s      = 2'd0;
      idx_v          = 3'd0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx_v = {1'b0, last_grant_r} + 3'(k);
         idx_v = (idx_v >= 3'(NUM_REQ)) ? (idx_v - 3'(NUM_REQ)) : idx_v;
         if (!win_found_s && in_valid_ext_s[idx_v[1:0]]) begin
            win_found_s = 1'b1;
            win_idx_s   = idx_v[1:0];
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Winner packet select
   always_comb begin
      sel_data_s = {WIDTH_packet{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx_s == 2'(i)) begin
            sel_data_s = in_data[i*WIDTH_packet +: WIDTH_packet];
         end else begin
            sel_data_s = sel_data_s;
         end
      end
   end

   // Handshake decode and next-state logic
   always_comb begin
      slot_avail_s = (state_r == EMPTY) || out_ready;
      accept_s     = win_found_s && slot_avail_s && !reset;
      out_fire_s   = (state_r == FULL) && out_ready;
      in_ready     = {NUM_REQ{1'b0}};
      state_next_s = state_r;
      if (accept_s) begin
         in_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
      end else begin
         in_ready = {NUM_REQ{1'b0}};
      end
      case (state_r)
         EMPTY:   state_next_s = accept_s ? FULL : EMPTY;
         FULL:    state_next_s = (out_fire_s && !accept_s) ? EMPTY : FULL;
         default: state_next_s = EMPTY;
      endcase
   end

   // State, output slot and round-robin pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= EMPTY;
         out_data_r   <= {WIDTH_packet{1'b0}};
         grant_id_r   <= 2'd0;
         last_grant_r <= 2'(NUM_REQ - 1);
      end else begin
         state_r <= state_next_s;
         if (accept_s) begin
            out_data_r   <= sel_data_s;
            grant_id_r   <= win_idx_s;
            last_grant_r <= win_idx_s;
         end
      end
   end

   assign out_valid = (state_r == FULL);
   assign out_data  = out_data_r;
   assign grant_id  = grant_id_r;
   assign busy      = (|in_valid) || out_valid;

`ifdef ARB_STATS_EN
   logic [NUM_REQ*WIDTH_cnt-1:0] grant_cnt_r;

   // Saturating accepted-transfer counters, one per requester
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_cnt_r <= {(NUM_REQ*WIDTH_cnt){1'b0}};
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (in_ready[i] && (grant_cnt_r[i*WIDTH_cnt +: WIDTH_cnt] != {WIDTH_cnt{1'b1}})) begin
               grant_cnt_r[i*WIDTH_cnt +: WIDTH_cnt] <=
                  grant_cnt_r[i*WIDTH_cnt +: WIDTH_cnt] + WIDTH_cnt'(1);
            end
         end
      end
   end

   assign grant_cnt = grant_cnt_r;
`endif

endmodule

// File: tb/tb_router_port_arbiter.sv
// Directed-vector bench for router_port_arbiter; an output monitor checks every
// delivered packet against a scoreboard queue filled when inputs are accepted.
module tb_router_port_arbiter;

   localparam int W  = 14;
   localparam int NR = 3;
   localparam int WC = 4;

   typedef struct packed {
      logic [1:0]   id;
      logic [W-1:0] data;
   } item_t;

   logic              clk;
   logic              reset;
   logic [NR-1:0]     in_valid;
   logic [W-1:0]      d [NR];
   logic [NR*W-1:0]   in_data;
   logic [NR-1:0]     in_ready;
   logic              out_valid;
   logic [W-1:0]      out_data;
   logic              out_ready;
   logic [1:0]        grant_id;
   logic              busy;
`ifdef ARB_STATS_EN
   logic [NR*WC-1:0]  grant_cnt;
`endif

   item_t q[$];
   int    n_vec;
   int    n_err;

   assign in_data = {d[2], d[1], d[0]};

   router_port_arbiter #(
      .WIDTH_packet(W),
      .NUM_REQ(NR),
      .WIDTH_cnt(WC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_ready(out_ready),
      .grant_id(grant_id),
      .busy(busy)
`ifdef ARB_STATS_EN
      ,
      .grant_cnt(grant_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1);
   end

   // Output monitor: every delivered packet must match the oldest expected one
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         item_t e;
         n_vec++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output: got id=%0d data=%h, expected nothing", grant_id, out_data);
         end else begin
            e = q.pop_front();
            if (grant_id !== e.id || out_data !== e.data) begin
               n_err++;
               $display("FAIL output: got id=%0d data=%h, expected id=%0d data=%h",
                        grant_id, out_data, e.id, e.data);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One cycle: drive, check in_ready/out_valid mid-cycle, push expected packet
   task automatic step(input logic [NR-1:0] v, input logic ordy,
                       input logic [NR-1:0] exp_rdy, input logic exp_ov);
      item_t e;
      in_valid  = v;
      out_ready = ordy;
      @(negedge clk);
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(exp_ov));
      check("busy", 32'(busy), 32'((|v) || exp_ov));
      for (int i = 0; i < NR; i++) begin
         if (exp_rdy[i]) begin
            e.id   = 2'(i);
            e.data = d[i];
            q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      reset     = 1'b1;
      in_valid  = 3'b000;
      out_ready = 1'b0;
      d[0] = 14'h0100; d[1] = 14'h0201; d[2] = 14'h0302;
      @(posedge clk);
      #1;
      // reset state, requests present but blocked
      step(3'b111, 1'b1, 3'b000, 1'b0);
      check("rst_out_data", 32'(out_data), 32'h0);
      check("rst_grant_id", 32'(grant_id), 32'h0);

      // full rotation, back to back
      reset = 1'b0;
      step(3'b111, 1'b1, 3'b001, 1'b0);
      step(3'b111, 1'b1, 3'b010, 1'b1);
      step(3'b111, 1'b1, 3'b100, 1'b1);
      step(3'b111, 1'b1, 3'b001, 1'b1);
      step(3'b111, 1'b1, 3'b010, 1'b1);
      step(3'b111, 1'b1, 3'b100, 1'b1);
      step(3'b000, 1'b1, 3'b000, 1'b1);
      step(3'b000, 1'b1, 3'b000, 1'b0);

      // single active requester 2
      d[2] = 14'h02A5;
      step(3'b100, 1'b1, 3'b100, 1'b0);
      step(3'b100, 1'b1, 3'b100, 1'b1);
      step(3'b100, 1'b1, 3'b100, 1'b1);
      step(3'b000, 1'b1, 3'b000, 1'b1);
      step(3'b000, 1'b1, 3'b000, 1'b0);

      // backpressure hold, then requester 2 wins on release
      d[1] = 14'h0011;
      step(3'b010, 1'b0, 3'b010, 1'b0);
      d[0] = 14'h1234;
      d[2] = 14'h0ABC;
      for (int k = 0; k < 4; k++) begin
         step(3'b101, 1'b0, 3'b000, 1'b1);
         check("hold_data", 32'(out_data), 32'h0011);
         check("hold_id", 32'(grant_id), 32'd1);
      end
      step(3'b101, 1'b1, 3'b100, 1'b1);

      // reset while FULL discards the held packet
      reset = 1'b1;
      step(3'b000, 1'b0, 3'b000, 1'b1);
      q.delete();
      check("rst2_out_valid", 32'(out_valid), 32'h0);
      check("rst2_out_data", 32'(out_data), 32'h0);
      check("rst2_grant_id", 32'(grant_id), 32'h0);
      reset = 1'b0;
      step(3'b111, 1'b1, 3'b001, 1'b0);

      // requester 1 withdraws while blocked: pointer unchanged
      step(3'b010, 1'b0, 3'b000, 1'b1);
      step(3'b100, 1'b1, 3'b100, 1'b1);
      step(3'b011, 1'b1, 3'b001, 1'b1);
      step(3'b000, 1'b1, 3'b000, 1'b1);
      step(3'b000, 1'b1, 3'b000, 1'b0);

`ifdef ARB_STATS_EN
      reset = 1'b1;
      step(3'b000, 1'b0, 3'b000, 1'b0);
      reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step(3'b001, 1'b1, 3'b001, (k != 0));
      end
      step(3'b000, 1'b1, 3'b000, 1'b1);
      check("grant_cnt", 32'(grant_cnt), 32'h00F);
`endif

      step(3'b000, 1'b0, 3'b000, 1'b0);
      check("scoreboard_empty", 32'(q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/router_port_arbiter.md
ROUTER_PORT_ARBITER -- requirements
Module: router_port_arbiter

Interface
REQ-001 Parameter WIDTH_packet, default 14, SHALL set the packet width in bits.
REQ-002 Parameter NUM_REQ, default 3, SHALL set the requester count (index 0 parent_in, 1 child1_in, 2 child2_in); legal range 2..4.
REQ-003 Parameter WIDTH_cnt, default 16, SHALL set the grant counter width (used only under ARB_STATS_EN).
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  NUM_REQ  per-requester packet-present flag.
REQ-007 in_data  input  NUM_REQ*WIDTH_packet  per-requester packet; requester i occupies bits [i*WIDTH_packet +: WIDTH_packet].
REQ-008 in_ready  output  NUM_REQ  per-requester accept strobe; at most one bit high per cycle.
REQ-009 out_valid  output  1  output register holds a packet.
REQ-010 out_data  output  WIDTH_packet  registered winning packet.
REQ-011 out_ready  input  1  downstream accept.
REQ-012 grant_id  output  2  index of the requester whose packet sits in the output register.
REQ-013 busy  output  1  high when any in_valid is high or out_valid is high.

Function
REQ-014 A transfer on requester i SHALL occur in a cycle where in_valid[i] and in_ready[i] are both high; on output, when out_valid and out_ready are both high.
REQ-015 The block SHALL be a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 Slot-available condition: state EMPTY, or state FULL with out_ready=1 in the same cycle.
REQ-017 in_ready SHALL go high only for the arbitration winner, only when the slot is available and that requester's in_valid is high; in_ready SHALL be combinational from in_valid, out_ready and state.
REQ-018 Winner: round-robin; search starts at index (last_grant+1) mod NUM_REQ and picks the first requester with in_valid high.
REQ-019 last_grant SHALL update to the winner index only on an accepted input transfer.
REQ-020 On acceptance, out_data and grant_id SHALL load on the next edge; latency from input transfer to out_valid is exactly 1 cycle.
REQ-021 EMPTY->FULL on accept; FULL->EMPTY on output transfer with no accept; FULL->FULL on output transfer with a simultaneous accept (back-to-back, 1 packet/cycle throughput).
REQ-022 While FULL and out_ready=0, out_data, grant_id and out_valid SHALL hold stable and all in_ready SHALL be 0.
REQ-023 A requester deasserting in_valid without a transfer SHALL lose its turn with no pointer change.
REQ-024 With a single active requester, that requester SHALL be granted every available slot.
REQ-025 With all NUM_REQ requesters continuously valid and out_ready=1, grants SHALL rotate 0,1,..,NUM_REQ-1,0 with no gap cycles.

Reset
REQ-026 On reset at a clock edge: state EMPTY, out_valid=0, out_data=0, grant_id=0, last_grant=NUM_REQ-1 (requester 0 wins first).
REQ-027 While reset is high, all in_ready SHALL be 0; a packet held mid-operation SHALL be discarded.
REQ-028 The first accept SHALL be possible in the first cycle after reset deasserts.

Configuration
REQ-029 Macro ARB_STATS_EN: when defined, output grant_cnt (NUM_REQ*WIDTH_cnt) SHALL exist; counter i increments on each accepted transfer from requester i, saturates at all-ones, clears on reset.
REQ-030 Without ARB_STATS_EN the grant_cnt port and counters SHALL be absent; all other behaviour identical.

Verification
REQ-031 Reset, then in_valid=3'b111, out_ready=1 for 6 cycles -> grant_id sequence 0,1,2,0,1,2, out_valid high from cycle 2 onward, no gaps.
REQ-032 Only requester 2 valid with data 14'h2A5, out_ready=1 -> in_ready=3'b100 each cycle, out_data=14'h2A5 one cycle later.
REQ-033 Fill output (req 1, data 14'h0011), hold out_ready=0 for 4 cycles with in_valid=3'b101 -> out_data stays 14'h0011, in_ready=0; on out_ready=1, req 2 wins that same cycle.
REQ-034 Assert reset while FULL -> next cycle out_valid=0, out_data=0, grant_id=0; first post-reset grant goes to requester 0.
REQ-035 ARB_STATS_EN with WIDTH_cnt=4, requester 0 alone for 20 transfers -> grant_cnt[0] saturates at 15, others 0.
